seg_scan_driver: RTL and testbench

- Parametrised multi-digit, time-multiplexed seven-segment driver for the Basys board display.
- Successor to the single-digit, fixed-anode decoder: drives NUM_DIGITS anodes in rotation, with:
  - hex decode (0-F);
  - per-digit decimal points;
  - optional leading-zero blanking;
  - tear-free frame-synchronous value updates.
- Sits between datapath blocks (e.g. the audio level meter) and the board's an/seg/dp pins.

---
 rtl/seg_pkg.sv | 21 ++
 rtl/seg_scan_driver_hex.sv | 11 +
 rtl/seg_scan_driver.sv | 147 ++++++++++++++
 tb/tb_seg_scan_driver.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment scan driver:
// the blank pattern, the active-low hex glyph table and the index width helper.
package seg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Active-low glyphs, bit order {g,f,e,d,c,b,a}; entry n is hex digit n.
   localparam logic [6:0] SEG_HEX [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   function automatic int idx_width(input int n);
      int w;
      w = (n > 1) ? $clog2(n) : 1;
      return w;
   endfunction

endpackage

// File: rtl/seg_scan_driver_hex.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex_to_seg7
   import seg_pkg::*;
(
   input  logic [3:0] hex_i,
   output logic [6:0] seg_o
);

   assign seg_o = SEG_HEX[hex_i];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed NUM_DIGITS seven-segment driver with frame-synchronous updates.
// Optional macro SEG_DIM_EN adds the brightness input and a per-slot anode on-window.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 100000,
   parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
   input  logic                    basys_clock,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load,
   input  logic                    blank_lz,
`ifdef SEG_DIM_EN
   input  logic [2:0]              brightness,
`endif
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic                    frame_done
);

   localparam int                IDX_W     = idx_width(NUM_DIGITS);
   localparam logic [CNT_W-1:0]  PRESC_MAX = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

   logic [CNT_W-1:0]        presc_q, presc_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] act_dig_q, act_dig_d, pend_dig_q, pend_dig_d;
   logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
   logic                    pend_v_q, pend_v_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d, fd_q, fd_d;

   logic                    tick_s, wrap_s, lz_zero_s, blank_s, on_s;
   logic [4*NUM_DIGITS-1:0] shift_dig_s;
   logic [NUM_DIGITS-1:0]   shift_dp_s;
   logic [6:0]              dec_seg_s;

`ifdef SEG_DIM_EN
   logic [2:0]  bright_q, bright_d;
   logic [31:0] dim_lim_s;
`endif

   hex_to_seg7 u_hex (
      .hex_i (shift_dig_s[3:0]),
      .seg_o (dec_seg_s)
   );

   // Scan counters and the pending/active value registers; active only moves at a frame wrap.
   always_comb begin
      tick_s     = (presc_q == PRESC_MAX);
      wrap_s     = tick_s && (idx_q == IDX_MAX);
      presc_d    = tick_s ? '0 : presc_q + CNT_W'(1);
      idx_d      = tick_s ? ((idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1)) : idx_q;
      act_dig_d  = act_dig_q;
      act_dp_d   = act_dp_q;
      pend_dig_d = pend_dig_q;
      pend_dp_d  = pend_dp_q;
      pend_v_d   = pend_v_q;
      if (wrap_s) begin
         pend_v_d = 1'b0;
         if (load) begin
            act_dig_d = digits_in;
            act_dp_d  = dp_in;
         end else if (pend_v_q) begin
            act_dig_d = pend_dig_q;
            act_dp_d  = pend_dp_q;
         end else begin
            act_dig_d = act_dig_q;
            act_dp_d  = act_dp_q;
         end
      end else if (load) begin
         pend_dig_d = digits_in;
         pend_dp_d  = dp_in;
         pend_v_d   = 1'b1;
      end else begin
         pend_v_d = pend_v_q;
      end
   end

   // Output stage: glyph select, leading-zero blanking and the anode guard/on-window.
   always_comb begin
      shift_dig_s = act_dig_q >> {idx_q, 2'b00};
      shift_dp_s  = act_dp_q >> idx_q;
      lz_zero_s   = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         lz_zero_s = lz_zero_s & ((i < int'(idx_q)) || (act_dig_q[4*i +: 4] == 4'd0));
      end
      blank_s = blank_lz && (idx_q != '0) && lz_zero_s;
      seg_d   = blank_s ? SEG_BLANK : dec_seg_s;
      dp_d    = ~shift_dp_s[0];
      fd_d    = wrap_s;
`ifdef SEG_DIM_EN
      bright_d  = (presc_q == '0) ? brightness : bright_q;
      dim_lim_s = ((32'(bright_q) + 32'd1) * 32'(REFRESH_DIV)) >> 3;
      on_s      = (presc_q != '0) && (32'(presc_q) < dim_lim_s);
`else
      on_s      = (presc_q != '0);
`endif
      an_d = on_s ? ~(NUM_DIGITS'(1) << idx_q) : '1;
   end

   // State and registered outputs, synchronous reset.
   always_ff @(posedge basys_clock) begin
      if (reset) begin
         presc_q    <= '0;
         idx_q      <= '0;
         act_dig_q  <= '0;
         act_dp_q   <= '0;
         pend_dig_q <= '0;
         pend_dp_q  <= '0;
         pend_v_q   <= 1'b0;
         an_q       <= '1;
         seg_q      <= SEG_BLANK;
         dp_q       <= 1'b1;
         fd_q       <= 1'b0;
`ifdef SEG_DIM_EN
         bright_q   <= 3'd0;
`endif
      end else begin
         presc_q    <= presc_d;
         idx_q      <= idx_d;
         act_dig_q  <= act_dig_d;
         act_dp_q   <= act_dp_d;
         pend_dig_q <= pend_dig_d;
         pend_dp_q  <= pend_dp_d;
         pend_v_q   <= pend_v_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
         fd_q       <= fd_d;
`ifdef SEG_DIM_EN
         bright_q   <= bright_d;
`endif
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomised self-checking bench for seg_scan_driver against a cycle-count based model.
module tb_seg_scan_driver;

   localparam int ND = 4;
   localparam int RD = 4;
   localparam int FRAME = ND * RD;

   localparam logic [6:0] HEX_TBL [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1;
   logic [15:0] digits_in = 16'h0000;
   logic [3:0]  dp_in = 4'h0;
   logic        load = 1'b0;
   logic        blank_lz = 1'b0;
`ifdef SEG_DIM_EN
   logic [2:0]  brightness = 3'd3;
`endif
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_done;

   seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
      .basys_clock (clk),
      .reset       (reset),
      .digits_in   (digits_in),
      .dp_in       (dp_in),
      .load        (load),
      .blank_lz    (blank_lz),
`ifdef SEG_DIM_EN
      .brightness  (brightness),
`endif
      .an          (an),
      .seg         (seg),
      .dp          (dp),
      .frame_done  (frame_done)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model: m_cnt = cycles since reset; digit slot and in-slot position follow by division.
   int         m_cnt = 0;
   logic [3:0] m_act [ND];
   logic [3:0] m_pend [ND];
   logic [3:0] m_act_dp = 4'h0, m_pend_dp = 4'h0;
   bit         m_pv = 1'b0;
   logic [3:0] e_an;
   logic [6:0] e_seg;
   logic       e_dp, e_fd;

   task automatic tick();
      int  pos, dig, lim;
      bit  lz;
      pos = m_cnt % RD;
      dig = (m_cnt / RD) % ND;
      if (reset) begin
         e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
         m_cnt = 0; m_pv = 1'b0; m_act_dp = 4'h0; m_pend_dp = 4'h0;
         for (int j = 0; j < ND; j++) begin
            m_act[j] = 4'h0;
            m_pend[j] = 4'h0;
         end
      end else begin
         lim = RD;
`ifdef SEG_DIM_EN
         lim = ((int'(brightness) + 1) * RD) >> 3;
`endif
         e_an = (pos != 0 && pos < lim) ? ~(4'b0001 << dig) : 4'hF;
         lz = blank_lz && (dig != 0);
         for (int j = dig; j < ND; j++) if (m_act[j] != 4'h0) lz = 1'b0;
         e_seg = lz ? 7'h7F : HEX_TBL[m_act[dig]];
         e_dp  = ~m_act_dp[dig];
         e_fd  = (pos == RD - 1) && (dig == ND - 1);
         if (e_fd) begin
            if (load) begin
               for (int j = 0; j < ND; j++) m_act[j] = digits_in[4*j +: 4];
               m_act_dp = dp_in;
            end else if (m_pv) begin
               m_act = m_pend;
               m_act_dp = m_pend_dp;
            end
            m_pv = 1'b0;
         end else if (load) begin
            for (int j = 0; j < ND; j++) m_pend[j] = digits_in[4*j +: 4];
            m_pend_dp = dp_in;
            m_pv = 1'b1;
         end
         m_cnt++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic align(input int phase);
      while ((m_cnt % FRAME) != phase) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      n_tests++;
      if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL reset an=%b seg=%b dp=%b fd=%b want 1111 1111111 1 0", an, seg, dp, frame_done);
      end
      reset = 1'b0;
   endtask

   // Runs n cycles, pulsing load with value d/p on cycle ld_at (-1: never).
   task automatic run_load(input string name, input int n, input int ld_at,
                           input logic [15:0] d, input logic [3:0] p);
      for (int c = 0; c < n; c++) begin
         load = (c == ld_at);
         if (c == ld_at) begin
            digits_in = d;
            dp_in = p;
         end
         tick();
         n_tests++;
         if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
            n_fail++;
            $display("FAIL %s c=%0d got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                     name, c, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
         end
      end
      load = 1'b0;
   endtask

   task automatic test_basic();
      blank_lz = 1'b0;
      run_load("basic", 3 * FRAME, 0, 16'h12AF, 4'b0100);
   endtask

   task automatic test_blanking();
      blank_lz = 1'b1;
      run_load("lz_0070", 3 * FRAME, 0, 16'h0070, 4'b0000);
      run_load("lz_0000", 3 * FRAME, 0, 16'h0000, 4'b0001);
   endtask

   task automatic test_last_wins();
      int ones;
      ones = 0;
      blank_lz = 1'b0;
      align(RD + 1);
      for (int c = 0; c < 3 * FRAME; c++) begin
         load = (c == 0) || (c == 6);
         digits_in = (c == 0) ? 16'h1111 : 16'h2222;
         dp_in = 4'b0000;
         tick();
         if (seg === 7'b1111001) ones++;
         n_tests++;
         if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
            n_fail++;
            $display("FAIL last_wins c=%0d got an=%b seg=%b fd=%b want an=%b seg=%b fd=%b",
                     c, an, seg, frame_done, e_an, e_seg, e_fd);
         end
      end
      load = 1'b0;
      n_tests++;
      if (ones != 0) begin
         n_fail++;
         $display("FAIL never_1111 got %0d cycles showing 1 want 0", ones);
      end
   endtask

   task automatic test_back_to_back();
      int pulses;
      pulses = 0;
      align(FRAME - 1);
      run_load("coincident", 2 * FRAME, 0, 16'h9C3E, 4'b1001);
      for (int c = 0; c < 4 * FRAME; c++) begin
         tick();
         if (frame_done === 1'b1) pulses++;
      end
      n_tests++;
      if (pulses != 4) begin
         n_fail++;
         $display("FAIL frame_done_rate got %0d pulses want 4", pulses);
      end
   endtask

   task automatic test_reset_mid();
      align(2 * RD + 1);
      digits_in = 16'h5B5B;
      dp_in = 4'hF;
      load = 1'b1;
      tick();
      load = 1'b0;
      reset = 1'b1;
      tick();
      n_tests++;
      if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_mid an=%b seg=%b dp=%b fd=%b want 1111 1111111 1 0", an, seg, dp, frame_done);
      end
      reset = 1'b0;
      blank_lz = 1'b0;
      run_load("after_reset", 3 * FRAME, -1, 16'h0000, 4'h0);
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         load = ($urandom_range(0, 5) == 0);
         digits_in = 16'($urandom);
         dp_in = 4'($urandom);
         if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
         if (($urandom_range(0, 3) == 0) && load) digits_in[15:8] = 8'h00;
         tick();
         n_tests++;
         if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
            n_fail++;
            $display("FAIL random c=%0d got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                     c, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
         end
      end
      load = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_blanking();
      test_last_wins();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
